column_loader: RTL

- Upstream feeder for the LED driver controller; turns framebuffer pixels into the 15 x 432-bit shift words the controller serialises.
- Reads one column of pixels (15 drivers x 9 LEDs) from a synchronous-read framebuffer RAM and expands RGB565 to 48-bit RGB.
- Double-buffered: fills a back buffer while the controller shifts the front buffer; swaps on the controller's EOC; issues SOF once column 0 is ready.

---
 rtl/column_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/column_loader.sv
// column_loader: reads one framebuffer column per pass, expands RGB565 to 48-bit RGB and
// double-buffers 15 x 432-bit words for the LED driver controller. Option: LOADER_TEST_PATTERN_EN.
module column_loader #(
  parameter int N_DRIVERS       = 15,
  parameter int LEDS_PER_DRIVER = 9,
  parameter int N_COLUMNS       = 8,
  parameter int ADDR_W          = 11
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic                             EOC,
`ifdef LOADER_TEST_PATTERN_EN
  input  logic                             test_pattern,
`endif
  output logic [ADDR_W-1:0]                ram_addr,
  output logic                             ram_rd,
  input  logic [15:0]                      ram_data,
  output logic [48*LEDS_PER_DRIVER-1:0]    data [N_DRIVERS],
  output logic                             SOF,
  output logic                             busy,
  output logic                             underrun
);
  localparam int WORD_W = 48*LEDS_PER_DRIVER;
  localparam int LW = (LEDS_PER_DRIVER > 1) ? $clog2(LEDS_PER_DRIVER) : 1;
  localparam int DW = (N_DRIVERS > 1) ? $clog2(N_DRIVERS) : 1;
  localparam int CW = (N_COLUMNS > 1) ? $clog2(N_COLUMNS) : 1;
  localparam logic [ADDR_W-1:0] COL_PIX = ADDR_W'(N_DRIVERS*LEDS_PER_DRIVER);

  typedef enum logic [1:0] {IDLE, FETCH, READY, WAIT_EOC} state_t;

  state_t              state;
  logic [LW-1:0]       rd_led, wr_led;
  logic [DW-1:0]       rd_drv, wr_drv;
  logic                wr_vld;
  logic [CW-1:0]       col_load, eoc_cnt;
  logic [ADDR_W-1:0]   col_base, next_base;
  logic [15:0]         pixel;
  logic [47:0]         px48;
  logic                col_done, eoc_act, last_eoc, more_cols, swap;
  logic [WORD_W-1:0]   back [N_DRIVERS];

  function automatic logic [47:0] expand(input logic [15:0] p);
    return {p[15:11], p[15:11], p[15:11], p[15],
            p[10:5],  p[10:5],  p[10:7],
            p[4:0],   p[4:0],   p[4:0],   p[4]};
  endfunction

`ifdef LOADER_TEST_PATTERN_EN
  logic [LW-1:0] col_mod;
  always_ff @(posedge clk) begin
    if (rst || frame_start) col_mod <= '0;
    else if (swap && more_cols)
      col_mod <= (col_mod == LW'(LEDS_PER_DRIVER-1)) ? '0 : col_mod + LW'(1);
  end
  always_comb pixel = test_pattern ? ((wr_led == col_mod) ? 16'hFFFF : 16'h0000) : ram_data;
`else
  assign pixel = ram_data;
`endif

  assign px48      = expand(pixel);
  assign next_base = col_base + COL_PIX;
  assign col_done  = wr_vld && (wr_drv == DW'(N_DRIVERS-1)) && (wr_led == LW'(LEDS_PER_DRIVER-1));
  assign eoc_act   = EOC && !frame_start && (state != IDLE);
  assign last_eoc  = eoc_act && (eoc_cnt == CW'(N_COLUMNS-1));
  assign more_cols = (col_load != CW'(N_COLUMNS-1));
  // A completing column-0 fill swaps on its own; every later swap waits for EOC.
  assign swap = (eoc_act && !last_eoc) ||
                (!frame_start && !eoc_act && state == FETCH && col_done && col_load == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ram_rd   <= 1'b0;
      ram_addr <= '0;
      rd_led   <= '0;
      rd_drv   <= '0;
      wr_vld   <= 1'b0;
      wr_led   <= '0;
      wr_drv   <= '0;
      col_load <= '0;
      col_base <= '0;
      eoc_cnt  <= '0;
      SOF      <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      SOF    <= 1'b0;
      wr_vld <= ram_rd;
      wr_led <= rd_led;
      wr_drv <= rd_drv;
      if (ram_rd) begin
        ram_addr <= ram_addr + ADDR_W'(1);
        if (rd_led == LW'(LEDS_PER_DRIVER-1)) begin
          rd_led <= '0;
          if (rd_drv == DW'(N_DRIVERS-1)) begin
            rd_drv <= '0;
            ram_rd <= 1'b0;
          end else rd_drv <= rd_drv + DW'(1);
        end else rd_led <= rd_led + LW'(1);
      end
      if (eoc_act && state == FETCH && !col_done) underrun <= 1'b1;

      if (frame_start) begin
        state    <= FETCH;
        busy     <= 1'b1;
        ram_rd   <= 1'b1;
        ram_addr <= '0;
        rd_led   <= '0;
        rd_drv   <= '0;
        wr_vld   <= 1'b0;
        col_load <= '0;
        col_base <= '0;
        eoc_cnt  <= '0;
      end else if (last_eoc) begin
        state  <= IDLE;
        busy   <= 1'b0;
        ram_rd <= 1'b0;
        wr_vld <= 1'b0;
      end else if (swap) begin
        if (eoc_act) eoc_cnt <= eoc_cnt + CW'(1);
        else         SOF     <= 1'b1;
        // Drop any read still in flight for an aborted column.
        wr_vld <= 1'b0;
        rd_led <= '0;
        rd_drv <= '0;
        if (more_cols) begin
          state    <= FETCH;
          ram_rd   <= 1'b1;
          ram_addr <= next_base;
          col_base <= next_base;
          col_load <= col_load + CW'(1);
        end else begin
          state  <= WAIT_EOC;
          ram_rd <= 1'b0;
        end
      end else if (state == FETCH && col_done) begin
        state <= READY;
      end
    end
  end

  // A pixel landing on the swap edge goes to both buffers so the front is never short one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < N_DRIVERS; d++) begin
        back[d] <= '0;
        data[d] <= '0;
      end
    end else begin
      for (int d = 0; d < N_DRIVERS; d++) begin
        if (swap) data[d] <= back[d];
        for (int l = 0; l < LEDS_PER_DRIVER; l++) begin
          if (wr_vld && wr_drv == DW'(d) && wr_led == LW'(l)) begin
            back[d][WORD_W-1-48*l -: 48] <= px48;
            if (swap) data[d][WORD_W-1-48*l -: 48] <= px48;
          end
        end
      end
    end
  end
endmodule
